// File: rtl/ising_checkerboard_lattice.sv
// rtl/ising_checkerboard_lattice.sv - ROWS x COLS Ising lattice with checkerboard Metropolis sweeps
// and a row-serial energy/magnetization measurement.
module ising_checkerboard_lattice #(
  parameter int ROWS        = 16,
  parameter int COLS        = 16,
  parameter int TEMP_WIDTH  = 8,
  parameter int JH_WIDTH    = 4,
  parameter int SWEEP_WIDTH = 16,
  parameter int ACC_WIDTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [SWEEP_WIDTH-1:0]      n_sweeps,
  input  logic [TEMP_WIDTH-1:0]       temperature,
  input  logic signed [JH_WIDTH-1:0]  coupling_j,
  input  logic signed [JH_WIDTH-1:0]  field_h,
  input  logic                        periodic,
  input  logic [15:0]                 seed,
  input  logic                        seed_load,
  output logic                        busy,
  output logic                        done,
  output logic [SWEEP_WIDTH-1:0]      sweeps_done,
  output logic [ROWS*COLS-1:0]        spins,
  output logic                        obs_valid,
  output logic signed [ACC_WIDTH-1:0] total_energy,
  output logic signed [ACC_WIDTH-1:0] magnetization
);
  localparam int N  = ROWS * COLS;
  localparam int RW = $clog2(ROWS);
  localparam int DW = JH_WIDTH + 6;
  localparam logic signed [DW-1:0]        TW_S = DW'(TEMP_WIDTH);
  localparam logic signed [ACC_WIDTH-1:0] ONE  = 1;
  localparam logic signed [ACC_WIDTH-1:0] MONE = -1;

  typedef enum logic [2:0] {IDLE, EVEN, ODD, MEAS, DONE} state_t;
  state_t state, state_nxt;

  logic [SWEEP_WIDTH-1:0]       n_q;
  logic [TEMP_WIDTH-1:0]        temp_q;
  logic signed [JH_WIDTH-1:0]   j_q, h_q;
  logic                         periodic_q;
  logic [RW-1:0]                row_q;
  logic [N-1:0]                 spin_vec;
  logic signed [ACC_WIDTH-1:0]  acc_e, acc_m;
  logic signed [DW-1:0]         jx, hx;
  logic                         start_ok, seed_ok, last_row;
  logic [SWEEP_WIDTH:0]         sweeps_inc;

  assign start_ok   = (state == IDLE) && start;
  assign seed_ok    = (state == IDLE) && seed_load;
  assign last_row   = (state == MEAS) && (row_q == RW'(ROWS - 1));
  assign sweeps_inc = {1'b0, sweeps_done} + 1'b1;
  assign jx         = {{(DW - JH_WIDTH){j_q[JH_WIDTH-1]}}, j_q};
  assign hx         = {{(DW - JH_WIDTH){h_q[JH_WIDTH-1]}}, h_q};
  assign spins      = spin_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = (n_sweeps == '0) ? MEAS : EVEN;
      EVEN: begin busy = 1'b1; state_nxt = ODD; end
      ODD: begin
        busy      = 1'b1;
        state_nxt = (sweeps_inc < {1'b0, n_q}) ? EVEN : MEAS;
      end
      MEAS: begin busy = 1'b1; if (last_row) state_nxt = DONE; end
      DONE: begin done = 1'b1; state_nxt = IDLE; end
      default: state_nxt = IDLE;
    endcase
    if (busy && abort) state_nxt = IDLE;
  end

  function automatic logic signed [3:0] nb_term(input logic present, input logic s);
    if (!present) return 4'sd0;
    return s ? 4'sd1 : -4'sd1;
  endfunction

  // Each cell reads its neighbours' registered spins, so one colour updates in parallel per cycle.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int   I   = r * COLS + c;
      localparam int   RU  = (r + ROWS - 1) % ROWS;
      localparam int   RD  = (r + 1) % ROWS;
      localparam int   CL  = (c + COLS - 1) % COLS;
      localparam int   CR  = (c + 1) % COLS;
      localparam logic PAR = 1'((r + c) % 2);
      logic                    s_q, flip, upd;
      logic [15:0]             lfsr_q, seeded;
      logic signed [3:0]       nb;
      logic signed [DW-1:0]    nbx, field, de;
      logic [TEMP_WIDTH-1:0]   thr;

      always_comb begin
        nb = nb_term((r != 0) || periodic_q, spin_vec[RU*COLS + c])
           + nb_term((r != ROWS - 1) || periodic_q, spin_vec[RD*COLS + c])
           + nb_term((c != 0) || periodic_q, spin_vec[r*COLS + CL])
           + nb_term((c != COLS - 1) || periodic_q, spin_vec[r*COLS + CR]);
        nbx   = {{(DW - 4){nb[3]}}, nb};
        field = jx * nbx + hx;
        de    = s_q ? (field <<< 1) : -(field <<< 1);
        thr   = (de >= TW_S) ? '0 : (temp_q >> de);
        flip  = de[DW-1] || (de == '0) || (lfsr_q[TEMP_WIDTH-1:0] < thr);
        upd   = ((state == EVEN) && !PAR) || ((state == ODD) && PAR);
        seeded = seed ^ 16'(I);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s_q    <= PAR;
          lfsr_q <= 16'hACE1 ^ 16'(I);
        end else begin
          if (upd && flip) s_q <= ~s_q;
          if (seed_ok)
            lfsr_q <= (seeded == 16'h0) ? 16'h0001 : seeded;
          else if (state == EVEN || state == ODD)
            lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
      end

      assign spin_vec[I] = s_q;
    end
  end

  logic [COLS-1:0]             grid [ROWS];
  logic [COLS-1:0]             cur, nxt;
  logic [RW-1:0]               row_nxt;
  logic signed [ACC_WIDTH-1:0] bond_sum, mag_sum, row_e, jacc, hacc;

  for (genvar r = 0; r < ROWS; r++) begin : g_grid
    assign grid[r] = spin_vec[r*COLS +: COLS];
  end

  assign jacc = {{(ACC_WIDTH - JH_WIDTH){j_q[JH_WIDTH-1]}}, j_q};
  assign hacc = {{(ACC_WIDTH - JH_WIDTH){h_q[JH_WIDTH-1]}}, h_q};

  // Each row owns its right and bottom bonds, so every bond is counted exactly once.
  always_comb begin
    row_nxt  = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
    cur      = grid[row_q];
    nxt      = grid[row_nxt];
    bond_sum = '0;
    mag_sum  = '0;
    for (int c = 0; c < COLS; c++) begin
      mag_sum = mag_sum + (cur[c] ? ONE : MONE);
      if (c < COLS - 1 || periodic_q)
        bond_sum = bond_sum + ((cur[c] ~^ cur[(c+1) % COLS]) ? ONE : MONE);
      if (row_q != RW'(ROWS - 1) || periodic_q)
        bond_sum = bond_sum + ((cur[c] ~^ nxt[c]) ? ONE : MONE);
    end
    row_e = -(jacc * bond_sum) - (hacc * mag_sum);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q           <= '0;
      temp_q        <= '0;
      j_q           <= '0;
      h_q           <= '0;
      periodic_q    <= 1'b0;
      sweeps_done   <= '0;
      row_q         <= '0;
      acc_e         <= '0;
      acc_m         <= '0;
      obs_valid     <= 1'b0;
      total_energy  <= '0;
      magnetization <= '0;
    end else begin
      row_q <= (state == MEAS) ? row_q + RW'(1) : '0;
      if (start_ok) begin
        n_q         <= n_sweeps;
        temp_q      <= temperature;
        j_q         <= coupling_j;
        h_q         <= field_h;
        periodic_q  <= periodic;
        sweeps_done <= '0;
        obs_valid   <= 1'b0;
        acc_e       <= '0;
        acc_m       <= '0;
      end
      if (state == ODD) sweeps_done <= sweeps_inc[SWEEP_WIDTH-1:0];
      if (state == MEAS) begin
        acc_e <= acc_e + row_e;
        acc_m <= acc_m + mag_sum;
      end
      if (last_row && !abort) begin
        total_energy  <= acc_e + row_e;
        magnetization <= acc_m + mag_sum;
        obs_valid     <= 1'b1;
      end
    end
  end
endmodule
